// File: rtl/pwm_capture.sv
// pwm_capture: recovers the duty cycle (0..127) and period of an incoming
// PWM waveform in the clk_256k domain. It also flags out-of-range periods and
// loss of signal.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int PERIOD_NOM = 128,
  parameter int PERIOD_TOL = 8,
  parameter int TIMEOUT    = 512
) (
  input  logic             clk_256k,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [6:0]       duty_out,
  output logic             duty_valid,
  output logic [CNT_W-1:0] period_out,
  output logic             period_err,
  output logic             signal_lost
);

  // The idle counter is one bit wider than TIMEOUT needs. Saturating at
  // all-ones therefore parks it above TIMEOUT-1, so a quiet interval fires
  // only once.
  localparam int IDLE_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  P_MIN    = CNT_W'(PERIOD_NOM - PERIOD_TOL);
  localparam logic [CNT_W-1:0]  P_MAX    = CNT_W'(PERIOD_NOM + PERIOD_TOL);
  localparam logic [IDLE_W-1:0] IDLE_MAX = '1;
  localparam logic [IDLE_W-1:0] IDLE_HIT = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {WAIT, MEASURE, STUCK} state_t;

  logic              sync1_q, s_q, s_prev_q;
  logic              rise, fall, timeout, in_range;
  logic [IDLE_W-1:0] idle_q;
  logic [CNT_W-1:0]  period_cnt_q, high_cnt_q;
  logic [6:0]        duty_sat;
  state_t            state_q;
  logic [6:0]        duty_q;
  logic              valid_q, err_q, lost_q;
  logic [CNT_W-1:0]  period_q;

  // Two-flop synchronizer, plus one more stage for edge detection.
  always_ff @(posedge clk_256k) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      sync1_q  <= pwm_in;
      s_q      <= sync1_q;
      s_prev_q <= s_q;
    end
  end

  assign rise = s_q & ~s_prev_q;
  assign fall = ~s_q & s_prev_q;

  // Count the cycles since the last edge of either polarity, saturating.
  always_ff @(posedge clk_256k) begin
    if (rst)                   idle_q <= '0;
    else if (rise | fall)      idle_q <= '0;
    else if (idle_q != IDLE_MAX) idle_q <= idle_q + IDLE_W'(1);
  end

  // An edge in the threshold cycle means the line was not quiet, so no timeout.
  assign timeout  = (idle_q == IDLE_HIT) && !rise && !fall;
  assign in_range = (period_cnt_q >= P_MIN) && (period_cnt_q <= P_MAX);
  assign duty_sat = (high_cnt_q > CNT_W'(127)) ? 7'd127 : high_cnt_q[6:0];

  // Measurement FSM: rise closes a period, quiet line forces STUCK.
  always_ff @(posedge clk_256k) begin
    if (rst) begin
      state_q      <= WAIT;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      period_q     <= '0;
      err_q        <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rise) begin
        state_q      <= MEASURE;
        period_cnt_q <= CNT_W'(1);
        high_cnt_q   <= CNT_W'(1);
        // Only a rise that closes a full window reports.
        // Rises out of WAIT/STUCK just arm the measurement.
        if (state_q == MEASURE) begin
          period_q <= period_cnt_q;
          lost_q   <= 1'b0;
          if (in_range) begin
            duty_q  <= duty_sat;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
          end else begin
            err_q   <= 1'b1;
          end
        end
      end else if (timeout) begin
        // A stuck line reads as 0% or 100% duty, depending on its level.
        state_q      <= STUCK;
        period_cnt_q <= '0;
        high_cnt_q   <= '0;
        lost_q       <= 1'b1;
        duty_q       <= s_q ? 7'd127 : 7'd0;
        valid_q      <= 1'b1;
        period_q     <= '0;
        err_q        <= 1'b0;
      end else if (state_q == MEASURE) begin
        if (period_cnt_q != CNT_MAX) period_cnt_q <= period_cnt_q + CNT_W'(1);
        if (s_q && high_cnt_q != CNT_MAX) high_cnt_q <= high_cnt_q + CNT_W'(1);
      end
    end
  end

  assign duty_out    = duty_q;
  assign duty_valid  = valid_q;
  assign period_out  = period_q;
  assign period_err  = err_q;
  assign signal_lost = lost_q;

endmodule
